// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit and its controller.
package md_defs;

    // Width of the MDCtr op-select bus.
    localparam int unsigned MD_CTR_W = 3;

    // Default commit latencies, counted from the start edge.
    localparam int unsigned MUL_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF = 10;

    // Latency counter width; covers the legal latency range 1..15.
    localparam int unsigned MD_CNT_W = 4;

    // Op-select encodings. Code 7 is unused and behaves as MD_NONE.
    typedef enum logic [MD_CTR_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // Sequencer states.
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_e;

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath. Produces the full {HI,LO} result
// for the selected op; ops that do not produce a result, and divides by zero,
// return the current {HI,LO} so a commit leaves the registers unchanged.
module md_calc
    import md_defs::*;
(
    input  logic [31:0]         A1,
    input  logic [31:0]         A2,
    input  logic [MD_CTR_W-1:0] MDCtr,
    input  logic [31:0]         hi,
    input  logic [31:0]         lo,
    output logic [63:0]         result
);

    logic signed [63:0] a_sext;
    logic signed [63:0] b_sext;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_mag_safe;
    logic [31:0] b_u_safe;
    logic [31:0] mag_quo;
    logic [31:0] mag_rem;
    logic [31:0] s_quo;
    logic [31:0] s_rem;
    logic [31:0] u_quo;
    logic [31:0] u_rem;
    logic        b_zero;

    // Low 64 bits of a 64x64 product of sign-extended operands is the exact
    // signed 32x32 product.
    assign a_sext = {{32{A1[31]}}, A1};
    assign b_sext = {{32{A2[31]}}, A2};
    assign prod_s = a_sext * b_sext;
    assign prod_u = {32'd0, A1} * {32'd0, A2};

    assign b_zero = (A2 == 32'd0);

    // Signed divide is done on magnitudes with the signs reapplied afterwards.
    // 0x80000000 / -1 falls out naturally: the magnitude quotient 0x80000000
    // negates back to itself and the remainder is zero.
    assign a_mag      = A1[31] ? (32'd0 - A1) : A1;
    assign b_mag      = A2[31] ? (32'd0 - A2) : A2;
    assign b_mag_safe = b_zero ? 32'd1 : b_mag;
    assign b_u_safe   = b_zero ? 32'd1 : A2;

    assign mag_quo = a_mag / b_mag_safe;
    assign mag_rem = a_mag % b_mag_safe;
    assign s_quo   = (A1[31] ^ A2[31]) ? (32'd0 - mag_quo) : mag_quo;
    assign s_rem   = A1[31] ? (32'd0 - mag_rem) : mag_rem;

    assign u_quo = A1 / b_u_safe;
    assign u_rem = A1 % b_u_safe;

    // Result select; anything without a product/quotient keeps {HI,LO}.
    always_comb begin
        result = {hi, lo};
        case (MDCtr)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   if (!b_zero) result = {s_rem, s_quo};
            MD_DIVU:  if (!b_zero) result = {u_rem, u_quo};
            MD_NONE, MD_MTHI, MD_MTLO: result = {hi, lo};
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at the start edge and held in a pending register;
// HI/LO are committed when the latency counter expires, which is also the
// edge on which busy falls.
module md_unit
    import md_defs::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         A1,
    input  logic [31:0]         A2,
    input  logic [MD_CTR_W-1:0] MDCtr,
    input  logic                start,
    output logic                busy,
    output logic [31:0]         HI,
    output logic [31:0]         LO
);

    md_state_e            state;
    md_state_e            next_state;
    logic [MD_CNT_W-1:0]  count;
    logic [63:0]          pending;
    logic [63:0]          calc_res;
    logic [31:0]          hi_q;
    logic [31:0]          lo_q;

    logic accept;
    logic is_md;
    logic is_mul;
    logic done;

    md_calc u_calc (
        .A1     (A1),
        .A2     (A2),
        .MDCtr  (MDCtr),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (calc_res)
    );

    assign accept = (state == ST_IDLE) && start;
    assign is_mul = (MDCtr == MD_MULT) || (MDCtr == MD_MULTU);
    assign is_md  = is_mul || (MDCtr == MD_DIV) || (MDCtr == MD_DIVU);
    // count holds the edges still to go; the commit edge is the one that
    // takes it from 1 to 0.
    assign done   = (state == ST_RUN) && (count == MD_CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state logic: a multi-cycle op enters RUN, counter expiry returns.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept && is_md) next_state = ST_RUN;
            ST_RUN:  if (done)            next_state = ST_IDLE;
            default:                      next_state = ST_IDLE;
        endcase
    end

    // Output logic: busy for the whole RUN residency.
    always_comb begin
        busy = 1'b0;
        if (state == ST_RUN) busy = 1'b1;
    end

    // Latency counter and pending result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            pending <= '0;
        end else if (accept && is_md) begin
            count   <= is_mul ? MD_CNT_W'(MUL_LAT) : MD_CNT_W'(DIV_LAT);
            pending <= calc_res;
        end else if (state == ST_RUN) begin
            count   <= count - MD_CNT_W'(1);
        end
    end

    // HI/LO: commit on counter expiry, direct writes for mthi/mtlo when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (done) begin
            hi_q <= pending[63:32];
            lo_q <= pending[31:0];
        end else if (accept && (MDCtr == MD_MTHI)) begin
            hi_q <= A1;
        end else if (accept && (MDCtr == MD_MTLO)) begin
            lo_q <= A1;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A1;
    logic [31:0] A2;
    logic [2:0]  MDCtr;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Behavioural model: HI/LO, result waiting to land, edges until it lands.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_left;

    md_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .A1    (A1),
        .A2    (A2),
        .MDCtr (MDCtr),
        .start (start),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_res(input int op, input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          q, r;
        longint unsigned uq, ur;
        case (op)
            1: return sa * sb;
            2: return ua * ub;
            3: begin
                if (b == 0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4: begin
                if (b == 0) return {hi, lo};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return {hi, lo};
        endcase
    endfunction

    // Model update on each clock edge; asynchronous clear on reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_pend = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end else if (start) begin
            case (int'(MDCtr))
                1, 2, 3, 4: begin
                    m_pend = ref_res(int'(MDCtr), A1, A2, m_hi, m_lo);
                    m_left = (MDCtr <= 3'd2) ? 5 : 10;
                end
                5: m_hi = A1;
                6: m_lo = A1;
                default: ;
            endcase
        end
    end

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_left != 0});
            chk("HI", HI, m_hi);
            chk("LO", LO, m_lo);
        end
    end

    // Driver runs just after the falling edge; start is a one-cycle pulse and
    // the operands are scrambled afterwards since the unit must not hold them.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        MDCtr = op; A1 = a; A2 = b; start = 1;
        @(negedge clk);
        start = 0; MDCtr = 3'($urandom_range(0, 7)); A1 = $urandom; A2 = $urandom;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset = 0; start = 0; MDCtr = 0; A1 = 0; A2 = 0;
        chk_en = 1;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_HI", HI, 32'd0);
        chk("reset_LO", LO, 32'd0);
        reset = 1;
        @(negedge clk);

        // Signed mult: -2 * 3
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_HI_before", HI, 32'd0);
        count_busy(n);
        chk("mult_busy_cycles", n, 5);
        chk("mult_HI", HI, 32'hFFFF_FFFF);
        chk("mult_LO", LO, 32'hFFFF_FFFA);

        // Unsigned mult
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        count_busy(n);
        chk("multu_busy_cycles", n, 5);
        chk("multu_HI", HI, 32'hFFFF_FFFE);
        chk("multu_LO", LO, 32'h0000_0001);

        // Signed div: -7 / 2
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        chk("div_busy_cycles", n, 10);
        chk("div_LO", LO, 32'hFFFF_FFFD);
        chk("div_HI", HI, 32'hFFFF_FFFF);

        // Unsigned div: 100 / 7
        issue(3'd4, 32'd100, 32'd7);
        count_busy(n);
        chk("divu_LO", LO, 32'd14);
        chk("divu_HI", HI, 32'd2);

        // mthi/mtlo take effect at the start edge with no busy
        issue(3'd5, 32'h11, 32'h0);
        chk("mthi_HI", HI, 32'h11);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h22, 32'h0);
        chk("mtlo_LO", LO, 32'h22);

        // Divide by zero: full busy window, HI/LO untouched
        issue(3'd3, 32'd1234, 32'd0);
        count_busy(n);
        chk("divz_busy_cycles", n, 10);
        chk("divz_HI", HI, 32'h11);
        chk("divz_LO", LO, 32'h22);

        // Signed overflow
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        chk("ovf_LO", LO, 32'h8000_0000);
        chk("ovf_HI", HI, 32'h0);

        // mtlo while busy is ignored
        issue(3'd1, 32'd3, 32'd4);
        @(negedge clk);
        MDCtr = 3'd6; A1 = 32'h55; start = 1;
        @(negedge clk);
        start = 0;
        count_busy(n);
        chk("ignored_mtlo_LO", LO, 32'd12);
        chk("ignored_mtlo_HI", HI, 32'd0);

        // Reset during a div: abandoned immediately, nothing commits later
        issue(3'd4, 32'd1000, 32'd3);
        repeat (3) @(negedge clk);
        #2 reset = 0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (15) @(negedge clk);
        chk("rst_no_commit_HI", HI, 32'd0);
        chk("rst_no_commit_LO", LO, 32'd0);

        // Randomized traffic, including starts while busy
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            MDCtr = 3'($urandom_range(0, 7));
            A1 = pick();
            A2 = pick();
            @(negedge clk);
        end
        start = 0;
        count_busy(n);
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL drain_timeout: busy still high after %0d cycles, expected low", n);
        end
        @(negedge clk);
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
